// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared defaults and carry-lookahead helper for cla_pipe_addsub
package cla_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BLK    = 4;
  localparam int DEF_STAGES = 2;
  localparam int DEF_SW     = DEF_WIDTH / DEF_STAGES;
  localparam int DEF_NBLK   = DEF_SW / DEF_BLK;
  // Largest lookahead fan-in supported: bits per block and blocks per slice.
  localparam int MAXN = 16;

  // Fully expanded lookahead: c[j+1] = g[j] | p[j]g[j-1] | ... | p[j..0]c0.
  function automatic logic [MAXN:0] lookahead(input logic [MAXN-1:0] p,
                                              input logic [MAXN-1:0] g,
                                              input logic c0,
                                              input int n);
    logic [MAXN:0] c;
    logic term;
    c = '0;
    c[0] = c0;
    for (int j = 0; j < MAXN; j++) begin
      if (j < n) begin
        term = c0;
        for (int k = 0; k < MAXN; k++) if (k <= j) term = term & p[k];
        c[j+1] = term;
        for (int i = 0; i < MAXN; i++) begin
          if (i <= j) begin
            term = g[i];
            for (int k = 0; k < MAXN; k++) if (k > i && k <= j) term = term & p[k];
            c[j+1] = c[j+1] | term;
          end
        end
      end
    end
    return c;
  endfunction
endpackage

// File: rtl/cla_pipe_addsub_block.sv
// rtl/cla_pipe_addsub_block.sv - combinational BLK-bit lookahead block (cla_block)
module cla_block
  import cla_pkg::*;
#(
  parameter int BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           p,
  output logic           g,
  output logic           co
);
  logic [BLK-1:0] pv;
  logic [BLK-1:0] gv;
  logic [BLK:0]   c;
  logic           term;

  assign pv = a ^ b;
  assign gv = a & b;
  assign c  = (BLK+1)'(lookahead(MAXN'(pv), MAXN'(gv), ci, BLK));
  assign s  = pv ^ c[BLK-1:0];
  assign p  = &pv;
  assign co = c[BLK];

  always_comb begin
    g    = 1'b0;
    term = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      term = gv[i];
      for (int k = 0; k < BLK; k++) if (k > i) term = term & pv[k];
      g = g | term;
    end
  end
endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor, one slice per stage
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLK    = DEF_BLK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW   = WIDTH / STAGES;
  localparam int NBLK = SW / BLK;
  localparam int LAST = STAGES - 1;
  localparam int NR   = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH % (STAGES * BLK) != 0) begin : g_bad_width
    $error("cla_pipe_addsub: WIDTH must be a multiple of STAGES*BLK");
  end
  if (NBLK > MAXN || BLK > MAXN) begin : g_bad_fanin
    $error("cla_pipe_addsub: lookahead fan-in exceeds MAXN");
  end

  logic             adv;
  logic [WIDTH-1:0] op_x [STAGES];
  logic [WIDTH-1:0] op_b [STAGES];
  logic             op_c [STAGES];
  logic             op_v [STAGES];
  logic [WIDTH-1:0] nx   [STAGES];
  logic             nc   [STAGES];
  logic [WIDTH-1:0] nb   [NR];
  logic             c_msb;

  // rx rotates: the unconsumed slices of a shift down while finished sums enter at the top.
  logic [WIDTH-1:0] rx [STAGES];
  logic [WIDTH-1:0] rb [NR];
  logic             rc [STAGES];
  logic             rv [STAGES];
  logic             r_ovf;

  assign adv      = !rv[LAST] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign op_x[k] = a;
      assign op_b[k] = sub ? ~b : b;
      assign op_c[k] = sub | cin;
      assign op_v[k] = in_valid;
    end else begin : g_mid
      assign op_x[k] = rx[k-1];
      assign op_b[k] = rb[k-1];
      assign op_c[k] = rc[k-1];
      assign op_v[k] = rv[k-1];
    end

    logic [NBLK-1:0] bp;
    logic [NBLK-1:0] bg;
    logic [NBLK-1:0] bco;
    logic [NBLK:0]   bc;
    logic [SW-1:0]   ss;

    assign bc = (NBLK+1)'(lookahead(MAXN'(bp), MAXN'(bg), op_c[k], NBLK));

    for (genvar j = 0; j < NBLK; j++) begin : g_blk
      cla_block #(.BLK(BLK)) u_blk (
        .a  (op_x[k][j*BLK +: BLK]),
        .b  (op_b[k][j*BLK +: BLK]),
        .ci (bc[j]),
        .s  (ss[j*BLK +: BLK]),
        .p  (bp[j]),
        .g  (bg[j]),
        .co (bco[j])
      );
    end

    // Each block's local carry-out must agree with the slice lookahead.
    assert property (@(posedge clk) disable iff (rst) bco == bc[NBLK:1]);

    assign nx[k] = (op_x[k] >> SW) | (WIDTH'(ss) << (WIDTH - SW));
    assign nc[k] = bc[NBLK];

    if (k < LAST) begin : g_fwd
      assign nb[k] = op_b[k] >> SW;
    end
    if (k == LAST) begin : g_msb
      assign c_msb = ss[SW-1] ^ op_x[k][SW-1] ^ op_b[k][SW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        rx[k] <= '0;
        rc[k] <= 1'b0;
        rv[k] <= 1'b0;
      end
      for (int i = 0; i < NR; i++) rb[i] <= '0;
      r_ovf <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        rx[k] <= nx[k];
        rc[k] <= nc[k];
        rv[k] <= op_v[k];
      end
      for (int i = 0; i < LAST; i++) rb[i] <= nb[i];
      r_ovf <= c_msb ^ nc[LAST];
    end
  end

  assign out_valid = rv[LAST];
  assign sum       = rx[LAST];
  assign cout      = rc[LAST];
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - self-checking bench for cla_pipe_addsub
module tb_cla_pipe_addsub;
  localparam int W = 32;
  localparam int STAGES = 2;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  int n_checks = 0;
  int n_fail = 0;
  res_t exp_q[$];

  cla_pipe_addsub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  localparam logic [W-1:0] TA [6] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd5};
  localparam logic [W-1:0] TB [6] = '{32'h0000_0001, 32'h0, 32'h1, 32'd7, 32'h1, 32'd7};
  localparam logic         TC [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic         TS [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [W-1:0] TSUM [6] = '{32'h0001_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
  localparam logic         TCO [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic         TOV [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // Reference: unsigned arithmetic for sum/cout, exact signed arithmetic for overflow.
  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
    res_t r;
    longint sx, sy, sr;
    logic [W:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      sr = sx - sy;
      r.sum = x - y;
      r.cout = (x >= y);
    end else begin
      sr = sx + sy + (ci ? 64'sd1 : 64'sd0);
      u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r.sum = u[W-1:0];
      r.cout = u[W];
    end
    r.ovf = (sr > MAXS) || (sr < MINS);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input bit ici, input bit isb, input bit ordy,
                      output bit acc, output bit took, output bit ov, output bit ir, output res_t o);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ici; sub = isb; out_ready = ordy;
    #1;
    ir = in_ready;
    ov = out_valid;
    o = {sum, cout, ovf};
    acc = iv && in_ready;
    took = out_valid && ordy;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, sum, cout, ovf} !== 35'd0)
      begin n_fail++; $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, expected all 0", out_valid, sum, cout, ovf); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    bit acc, took, ov, ir, found;
    res_t o, got;
    int lat;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, TA[i], TB[i], TC[i], TS[i], 1'b1, acc, took, ov, ir, o);
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL dir_accept[%0d]: beat not accepted", i); end
      found = 0; lat = 0; got = '0;
      for (int n = 1; n <= 10 && !found; n++) begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, took, ov, ir, o);
        if (took) begin found = 1; lat = n; got = o; end
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL dir_timeout[%0d]: no result within 10 cycles", i); end
      else begin
        if (lat != STAGES) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, STAGES); end
        n_checks++;
        if (got !== {TSUM[i], TCO[i], TOV[i]})
          begin n_fail++; $display("FAIL dir_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                   i, got.sum, got.cout, got.ovf, TSUM[i], TCO[i], TOV[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc, took, ov, ir, ordy, prev_stall;
    res_t o, e, prev_o;
    logic [W-1:0] xa, xb;
    bit xc, xs;
    int sent, got;
    sent = 0; got = 0; prev_stall = 0; prev_o = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      xa = rnd_op(); xb = rnd_op(); xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
      ordy = (cyc >= 5);
      step(sent < 4, xa, xb, xc, xs, ordy, acc, took, ov, ir, o);
      if (ov && !ordy) begin
        n_checks++;
        if (ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0 while stalled", ir); end
        if (prev_stall) begin
          n_checks++;
          if (o !== prev_o) begin n_fail++; $display("FAIL bp_hold: got sum=%h expected held sum=%h", o.sum, prev_o.sum); end
        end
        prev_stall = 1; prev_o = o;
      end else prev_stall = 0;
      if (acc) begin exp_q.push_back(model(xa, xb, xc, xs)); sent++; end
      if (took) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got sum=%h expected no result", o.sum); end
        else begin
          e = exp_q.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL bp_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b", o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf); end
        end
        got++;
      end
    end
    n_checks++;
    if (got != 4 || sent != 4 || exp_q.size() != 0)
      begin n_fail++; $display("FAIL bp_count: got %0d results from %0d beats, expected 4 from 4", got, sent); end
    exp_q.delete();
  endtask

  task automatic test_throughput();
    bit acc, took, ov, ir;
    res_t o, e;
    logic [W-1:0] xa, xb;
    bit xc, xs;
    int sent, got, cyc;
    sent = 0; got = 0;
    for (cyc = 0; cyc < 60 && got < 20; cyc++) begin
      xa = rnd_op(); xb = rnd_op(); xc = 1'($urandom_range(0, 1)); xs = cyc[0];
      step(sent < 20, xa, xb, xc, xs, 1'b1, acc, took, ov, ir, o);
      if (sent < 20) begin
        n_checks++;
        if (!acc) begin n_fail++; $display("FAIL thru_accept: beat %0d not accepted at cycle %0d", sent, cyc); end
      end
      if (acc) begin exp_q.push_back(model(xa, xb, xc, xs)); sent++; end
      if (took) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL thru_extra: got sum=%h expected no result", o.sum); end
        else begin
          e = exp_q.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL thru_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b", o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf); end
        end
        got++;
      end
    end
    n_checks++;
    if (cyc != 20 + STAGES) begin n_fail++; $display("FAIL thru_cycles: got %0d cycles for 20 results, expected %0d", cyc, 20 + STAGES); end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    bit acc, took, ov, ir, found;
    res_t o, e;
    int lat;
    for (int i = 0; i < 2; i++) step(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b1, acc, took, ov, ir, o);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, sum, cout, ovf} !== 35'd0)
      begin n_fail++; $display("FAIL mid_reset: got valid=%b sum=%h cout=%b ovf=%b, expected all 0", out_valid, sum, cout, ovf); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, took, ov, ir, o);
      n_checks++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL mid_flush[%0d]: got out_valid=%b expected 0", i, ov); end
    end
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
    step(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b1, acc, took, ov, ir, o);
    found = 0; lat = 0;
    for (int n = 1; n <= 10 && !found; n++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, took, ov, ir, o);
      if (took) begin
        found = 1; lat = n;
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL mid_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b", o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf); end
      end
    end
    n_checks++;
    if (!found || lat != STAGES) begin n_fail++; $display("FAIL mid_latency: got found=%0d lat=%0d expected lat=%0d", found, lat, STAGES); end
  endtask

  task automatic test_random();
    bit acc, took, ov, ir, iv, ordy;
    res_t o, e;
    logic [W-1:0] xa, xb;
    bit xc, xs;
    for (int cyc = 0; cyc < 10000 + 20; cyc++) begin
      xa = rnd_op(); xb = rnd_op(); xc = 1'($urandom_range(0, 1)); xs = 1'($urandom_range(0, 1));
      iv = (cyc < 10000) && ($urandom_range(0, 3) != 0);
      ordy = (cyc >= 10000) || ($urandom_range(0, 3) != 0);
      step(iv, xa, xb, xc, xs, ordy, acc, took, ov, ir, o);
      n_checks++;
      if (ir !== (!ov || ordy)) begin n_fail++; $display("FAIL rand_in_ready: got %b expected %b", ir, (!ov || ordy)); end
      if (acc) exp_q.push_back(model(xa, xb, xc, xs));
      if (took) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra: got sum=%h expected no result", o.sum); end
        else begin
          e = exp_q.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL rand_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b", o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf); end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d results outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_throughput();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
